// File: rtl/subtractor_cla4_seq_if.sv
// rtl/subtractor_cla4_seq_if.sv - request/result bundle for the chunked sequential subtractor
interface subtractor_cla4_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, x, y, bin,
    input  busy, done, diff, bout, ovf, zero
  );

  modport slave (
    input  start, x, y, bin,
    output busy, done, diff, bout, ovf, zero
  );
endinterface

// File: rtl/subtractor_cla4_seq.sv
// rtl/subtractor_cla4_seq.sv - multi-cycle x - y - bin, CHUNK bits per cycle LSB first
module subtractor_cla4_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input logic                 i_clk,
  input logic                 i_rst,
  subtractor_cla4_seq_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [CW-1:0]          r_cnt;
  logic [WIDTH-1:0]       r_xr;
  logic [WIDTH-1:0]       r_yr;
  logic                   r_xs;
  logic                   r_ys;
  logic                   r_brw;
  logic [WIDTH-CHUNK-1:0] r_work;
  logic [WIDTH-1:0]       r_diff;
  logic                   r_bout;
  logic                   r_ovf;
  logic                   r_zero;

  logic [CHUNK:0]         w_sub;
  logic [CHUNK-1:0]       w_d;
  logic                   w_b;
  logic                   w_last;
  logic [WIDTH-1:0]       w_final;

  // Operands shift right so the active chunk always sits in the low bits;
  // finished chunks enter r_work from the top, so {d, r_work} is the full result.
  always_comb begin
    w_sub   = {1'b0, r_xr[CHUNK-1:0]} - {1'b0, r_yr[CHUNK-1:0]} - {{CHUNK{1'b0}}, r_brw};
    w_d     = w_sub[CHUNK-1:0];
    w_b     = w_sub[CHUNK];
    w_last  = (r_cnt == CW'(N - 1));
    w_final = {w_d, r_work};
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_xr    <= '0;
      r_yr    <= '0;
      r_xs    <= 1'b0;
      r_ys    <= 1'b0;
      r_brw   <= 1'b0;
      r_work  <= '0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b1;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_xr   <= bus.x;
            r_yr   <= bus.y;
            r_xs   <= bus.x[WIDTH-1];
            r_ys   <= bus.y[WIDTH-1];
            r_brw  <= bus.bin;
            r_cnt  <= '0;
            r_work <= '0;
          end
        end
        RUN: begin
          r_xr   <= {{CHUNK{1'b0}}, r_xr[WIDTH-1:CHUNK]};
          r_yr   <= {{CHUNK{1'b0}}, r_yr[WIDTH-1:CHUNK]};
          r_brw  <= w_b;
          r_work <= w_final[WIDTH-1:CHUNK];
          r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
          if (w_last) begin
            r_diff <= w_final;
            r_bout <= w_b;
            r_ovf  <= (r_xs != r_ys) && (w_final[WIDTH-1] != r_xs);
            r_zero <= (w_final == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (r_state != IDLE);
  assign bus.done = (r_state == DONE);
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;
  assign bus.ovf  = r_ovf;
  assign bus.zero = r_zero;
endmodule

// File: tb/tb_subtractor_cla4_seq.sv
// tb/tb_subtractor_cla4_seq.sv - directed and reference-model checks of subtractor_cla4_seq
module tb_subtractor_cla4_seq;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  subtractor_cla4_seq_if #(.WIDTH(WIDTH)) bus ();

  subtractor_cla4_seq #(.WIDTH(WIDTH), .CHUNK(4)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Issues one op and checks latency, busy hold, single done and results.
  // inj > 0 re-pulses start with other operands in that RUN cycle.
  task automatic do_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic bin, input int inj,
                       input logic [31:0] e_diff, input logic e_bout,
                       input logic e_ovf, input logic e_zero);
    int cyc;
    bit busy_ok;
    @(negedge clk);
    bus.start = 1'b1; bus.x = x; bus.y = y; bus.bin = bin;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.x = ~x; bus.y = x ^ y; bus.bin = ~bin;
    cyc = 0;
    busy_ok = 1'b1;
    while (!bus.done && cyc < 40) begin
      if (!bus.busy) busy_ok = 1'b0;
      bus.start = (cyc == inj && inj > 0);
      if (cyc == inj && inj > 0) begin bus.x = 32'h0; bus.y = 32'h5; end
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    check({tag, " latency"}, 64'(cyc), 64'd8);
    check({tag, " busy_held"}, 64'(busy_ok), 64'd1);
    check({tag, " busy_done"}, 64'(bus.busy), 64'd1);
    check({tag, " diff"}, 64'(bus.diff), 64'(e_diff));
    check({tag, " bout"}, 64'(bus.bout), 64'(e_bout));
    check({tag, " ovf"}, 64'(bus.ovf), 64'(e_ovf));
    check({tag, " zero"}, 64'(bus.zero), 64'(e_zero));
    @(posedge clk); #1;
    check({tag, " done_pulse"}, 64'(bus.done), 64'd0);
    check({tag, " idle"}, 64'(bus.busy), 64'd0);
    check({tag, " hold"}, 64'(bus.diff), 64'(e_diff));
  endtask

  initial begin
    logic [32:0] full;
    logic [31:0] rx, ry;
    logic        rb;
    int          dones;

    bus.start = 1'b0; bus.x = '0; bus.y = '0; bus.bin = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst done", 64'(bus.done), 64'd0);
    check("rst diff", 64'(bus.diff), 64'd0);
    check("rst bout", 64'(bus.bout), 64'd0);
    check("rst ovf", 64'(bus.ovf), 64'd0);
    check("rst zero", 64'(bus.zero), 64'd1);
    rst = 1'b0;

    do_op("t1", 32'd5, 32'd3, 1'b0, 0, 32'd2, 1'b0, 1'b0, 1'b0);
    do_op("t2", 32'd0, 32'd1, 1'b0, 0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    do_op("t3a", 32'h8000_0000, 32'd1, 1'b0, 0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    do_op("t3b", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    do_op("t4a", 32'h10, 32'h01, 1'b0, 0, 32'h0F, 1'b0, 1'b0, 1'b0);
    do_op("t4b", 32'h1234, 32'h1234, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b1);
    do_op("t4c", 32'h0, 32'h0, 1'b1, 0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    do_op("t4d", 32'h1000_0000, 32'h0000_0001, 1'b1, 0, 32'h0FFF_FFFE, 1'b0, 1'b0, 1'b0);
    do_op("t5", 32'd100, 32'd58, 1'b0, 3, 32'd42, 1'b0, 1'b0, 1'b0);

    // Reset during RUN cycle 4 discards the op and suppresses done.
    @(negedge clk);
    bus.start = 1'b1; bus.x = 32'd9; bus.y = 32'd4; bus.bin = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t6 busy_pre", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6 busy", 64'(bus.busy), 64'd0);
    check("t6 done", 64'(bus.done), 64'd0);
    check("t6 diff", 64'(bus.diff), 64'd0);
    check("t6 zero", 64'(bus.zero), 64'd1);
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    check("t6 no_done", 64'(dones), 64'd0);
    do_op("t6 after", 32'd9, 32'd4, 1'b0, 0, 32'd5, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      rx = $urandom;
      ry = (i % 7 == 0) ? rx : $urandom;
      rb = 1'($urandom_range(0, 1));
      full = {1'b0, rx} - {1'b0, ry} - {32'd0, rb};
      do_op("t7", rx, ry, rb, 0, full[31:0], full[32],
            (rx[31] != ry[31]) && (full[31] != rx[31]), full[31:0] == 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
